// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single slow_memory line port between the I-cache and D-cache
//   refill/writeback paths. One requester owns the port at a time; on
//   contention the side not served last wins. The grant is held until
//   mem_ready (or until the requester withdraws). A sticky error flags a
//   grant that has waited TIMEOUT_CYC cycles without mem_ready.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   c_read_X/c_write_X/c_addr_X/    cache X request (X = I, D), held stable
//   c_wdata_X                       until c_ready_X
//   c_rdata_X, c_ready_X            read line / transaction done to cache X
//   mem_read/mem_write/mem_addr/    strobes and line to slow memory
//   mem_wdata
//   mem_rdata, mem_ready            read line / 1-cycle done from slow memory
//   owner                           00 idle, 01 I granted, 10 D granted
//   err_timeout                     sticky stalled-grant flag
module mem_arbiter #(
  parameter int FIRST_D     = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         c_read_I,
  input  logic         c_write_I,
  input  logic [27:0]  c_addr_I,
  input  logic [127:0] c_wdata_I,
  output logic [127:0] c_rdata_I,
  output logic         c_ready_I,
  input  logic         c_read_D,
  input  logic         c_write_D,
  input  logic [27:0]  c_addr_D,
  input  logic [127:0] c_wdata_D,
  output logic [127:0] c_rdata_D,
  output logic         c_ready_D,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [1:0]   owner,
  output logic         err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  // last_D starts as the opposite of the side that should win first.
  localparam logic        LP_LAST_D_RST = (FIRST_D == 0);
  localparam logic [15:0] LP_TO         = 16'(TIMEOUT_CYC);

  state_t      r_state, w_state_nxt;
  logic        r_last_d, w_last_d_nxt;
  logic [15:0] r_cnt;
  logic        r_err;
  logic        w_req_i, w_req_d;
  logic        w_grant;

  assign w_req_i = c_read_I | c_write_I;
  assign w_req_d = c_read_D | c_write_D;
  assign w_grant = (r_state != IDLE);

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= LP_LAST_D_RST;
    end else begin
      r_state  <= w_state_nxt;
      r_last_d <= w_last_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_d_nxt = r_last_d;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    c_ready_I    = 1'b0;
    c_ready_D    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // mem_ready here is ignored; strobes stay low, which also gives
        // slow_memory its mandatory gap cycle between transactions.
        if (w_req_i && w_req_d) w_state_nxt = r_last_d ? GNT_I : GNT_D;
        else if (w_req_i)       w_state_nxt = GNT_I;
        else if (w_req_d)       w_state_nxt = GNT_D;
      end
      GNT_I: begin
        mem_read  = c_read_I;
        mem_write = c_write_I;
        mem_addr  = c_addr_I;
        mem_wdata = c_wdata_I;
        if (mem_ready) begin
          c_ready_I    = 1'b1;
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b0;
        end else if (!w_req_i) begin
          // withdrawn request: release without touching round-robin history
          w_state_nxt = IDLE;
        end
      end
      GNT_D: begin
        mem_read  = c_read_D;
        mem_write = c_write_D;
        mem_addr  = c_addr_D;
        mem_wdata = c_wdata_D;
        if (mem_ready) begin
          c_ready_D    = 1'b1;
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b1;
        end else if (!w_req_d) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- timeout
  // The counter is held at 0 while idle, so it is zero on grant entry. The
  // error sets on the edge where the count reaches TIMEOUT_CYC, i.e. right
  // after the TIMEOUT_CYC-th grant cycle without mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (!w_grant) begin
        r_cnt <= '0;
      end else if (!mem_ready && (r_cnt != LP_TO)) begin
        r_cnt <= r_cnt + 16'd1;
        if (r_cnt == LP_TO - 16'd1) r_err <= 1'b1;
      end
    end
  end

  assign c_rdata_I   = mem_rdata;
  assign c_rdata_D   = mem_rdata;
  assign owner       = r_state;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         c_read_I, c_write_I, c_read_D, c_write_D;
  logic [27:0]  c_addr_I, c_addr_D;
  logic [127:0] c_wdata_I, c_wdata_D, c_rdata_I, c_rdata_D;
  logic         c_ready_I, c_ready_D;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [1:0]   owner;
  logic         err_timeout;

  mem_arbiter #(.FIRST_D(1), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_read_I(c_read_I), .c_write_I(c_write_I), .c_addr_I(c_addr_I),
    .c_wdata_I(c_wdata_I), .c_rdata_I(c_rdata_I), .c_ready_I(c_ready_I),
    .c_read_D(c_read_D), .c_write_D(c_write_D), .c_addr_D(c_addr_D),
    .c_wdata_D(c_wdata_D), .c_rdata_D(c_rdata_D), .c_ready_D(c_ready_D),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         side_d;
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    int           lat;
  } vec_t;

  typedef struct {
    logic [1:0]   owner;
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } exp_t;

  vec_t vecs[5];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    c_read_I = 0; c_write_I = 0; c_read_D = 0; c_write_D = 0;
  endtask

  task automatic drive(input vec_t v);
    if (v.side_d) begin
      c_read_D = v.rd; c_write_D = v.wr; c_addr_D = v.addr; c_wdata_D = v.wdata;
    end else begin
      c_read_I = v.rd; c_write_I = v.wr; c_addr_I = v.addr; c_wdata_I = v.wdata;
    end
  endtask

  task automatic do_reset();
    rst_n = 0; mem_ready = 0; mem_rdata = '0; clear_req();
    c_addr_I = '0; c_addr_D = '0; c_wdata_I = '0; c_wdata_D = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Waits (bounded) for a grant; idle cycles seen on the way must have
  // both strobes low.
  task automatic wait_grant(output int idle, output bit ok);
    idle = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (owner != 2'b00) begin ok = 1; return; end
      chk("idle_strobes", {mem_read, mem_write}, 2'b00);
      idle++;
    end
    total++; bad++;
    $display("FAIL grant_wait got=owner %0d want=nonzero", owner);
  endtask

  task automatic pulse_ready(input logic side_d);
    logic [127:0] rd;
    rd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    mem_rdata = rd; mem_ready = 1;
    #1;
    chk("ready_own", side_d ? c_ready_D : c_ready_I, 1'b1);
    chk("ready_other", side_d ? c_ready_I : c_ready_D, 1'b0);
    chk("rdata_I", c_rdata_I, rd);
    chk("rdata_D", c_rdata_D, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int   idle;
    bit   ok;
    vec_t v;
    exp_t e;

    vecs[0] = '{side_d:1'b0, rd:1'b1, wr:1'b0, addr:28'h0000010, wdata:128'h0, lat:2};
    vecs[1] = '{side_d:1'b1, rd:1'b0, wr:1'b1, addr:28'h0000020,
                wdata:128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, lat:3};
    vecs[2] = '{side_d:1'b1, rd:1'b1, wr:1'b0, addr:28'h0ABCDEF, wdata:128'h0, lat:1};
    vecs[3] = '{side_d:1'b0, rd:1'b0, wr:1'b1, addr:28'hFFFFFFF, wdata:{128{1'b1}}, lat:4};
    vecs[4] = '{side_d:1'b0, rd:1'b1, wr:1'b1, addr:28'h1234567,
                wdata:128'h5555_0000_AAAA_1111_2222_3333_4444_6666, lat:1};

    // reset state
    do_reset();
    #1;
    chk("rst_owner", owner, 2'b00);
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_addr", mem_addr, 28'h0);
    chk("rst_ready", {c_ready_I, c_ready_D}, 2'b00);
    chk("rst_err", err_timeout, 1'b0);
    // mem_ready while idle must be dropped
    @(negedge clk); mem_ready = 1; #1;
    chk("idle_ready_fwd", {c_ready_I, c_ready_D}, 2'b00);
    @(negedge clk); mem_ready = 0; #1;
    chk("idle_ready_owner", owner, 2'b00);

    // single-requester transaction table
    foreach (vecs[k]) begin
      v = vecs[k];
      @(negedge clk);
      drive(v);
      sbq.push_back('{owner: (v.side_d ? 2'b10 : 2'b01), rd: v.rd, wr: v.wr,
                      addr: v.addr, wdata: v.wdata});
      #1;
      chk("pre_owner", owner, 2'b00);
      wait_grant(idle, ok);
      e = sbq.pop_front();
      if (ok) begin
        chk("latency", idle, 0);
        chk("owner", owner, e.owner);
        chk("mem_read", mem_read, e.rd);
        chk("mem_write", mem_write, e.wr);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("no_early_ready", {c_ready_I, c_ready_D}, 2'b00);
        repeat (v.lat - 1) @(negedge clk);
        pulse_ready(v.side_d);
      end
      @(negedge clk);
      mem_ready = 0; clear_req();
      #1;
      chk("post_owner", owner, 2'b00);
      chk("post_strobes", {mem_read, mem_write}, 2'b00);
    end

    // simultaneous I read / D write after reset: D first
    do_reset();
    @(negedge clk);
    c_read_I = 1; c_addr_I = 28'h0000100;
    c_write_D = 1; c_addr_D = 28'h0000200; c_wdata_D = 128'hCAFE;
    wait_grant(idle, ok);
    chk("cont_first", owner, 2'b10);
    chk("cont_first_wr", mem_write, 1'b1);
    chk("cont_first_addr", mem_addr, 28'h0000200);
    pulse_ready(1'b1);
    @(negedge clk);
    mem_ready = 0; c_write_D = 0;
    #1;
    chk("cont_gap", owner, 2'b00);
    wait_grant(idle, ok);
    chk("cont_second", owner, 2'b01);
    chk("cont_second_addr", mem_addr, 28'h0000100);
    chk("cont_no_ready_D", c_ready_D, 1'b0);
    pulse_ready(1'b0);
    @(negedge clk);
    mem_ready = 0; clear_req();

    // continuous requests from both: D,I,D,I,D,I with one gap cycle each
    @(negedge clk);
    c_read_I = 1; c_addr_I = 28'h0000111;
    c_read_D = 1; c_addr_D = 28'h0000222;
    for (int k = 0; k < 6; k++)
      sbq.push_back('{owner: (k % 2 == 0) ? 2'b10 : 2'b01, rd: 1'b1, wr: 1'b0,
                      addr: (k % 2 == 0) ? 28'h0000222 : 28'h0000111, wdata: '0});
    for (int k = 0; k < 6; k++) begin
      wait_grant(idle, ok);
      e = sbq.pop_front();
      chk("alt_gap", idle, (k == 0) ? 0 : 1);
      chk("alt_owner", owner, e.owner);
      chk("alt_addr", mem_addr, e.addr);
      pulse_ready(e.owner == 2'b10);
      @(posedge clk); #1;
      mem_ready = 0;
    end
    @(negedge clk);
    clear_req();

    // abort: withdrawn D request releases without updating round-robin
    @(negedge clk);
    c_read_D = 1; c_addr_D = 28'h0000444;
    wait_grant(idle, ok);
    chk("abort_owner", owner, 2'b10);
    @(negedge clk);
    c_read_D = 0;
    #1;
    chk("abort_no_ready", c_ready_D, 1'b0);
    @(negedge clk); #1;
    chk("abort_idle", owner, 2'b00);
    @(negedge clk);
    c_read_I = 1; c_read_D = 1;
    wait_grant(idle, ok);
    chk("abort_keeps_rr", owner, 2'b10);
    pulse_ready(1'b1);
    @(negedge clk);
    mem_ready = 0; clear_req();

    // timeout: memory never answers
    @(negedge clk); #1;
    chk("to_pre_err", err_timeout, 1'b0);
    c_read_I = 1; c_addr_I = 28'h0000555;
    wait_grant(idle, ok);
    repeat (7) @(negedge clk);
    #1;
    chk("to_cycle8_err", err_timeout, 1'b0);
    @(negedge clk); #1;
    chk("to_after8_err", err_timeout, 1'b1);
    chk("to_no_abort", owner, 2'b01);
    @(negedge clk);
    c_read_I = 0;
    @(negedge clk); #1;
    chk("to_dropped_owner", owner, 2'b00);
    chk("to_sticky", err_timeout, 1'b1);

    // reset in the middle of a grant
    @(negedge clk);
    c_read_I = 1; c_addr_I = 28'h0000333;
    wait_grant(idle, ok);
    chk("mid_pre_read", mem_read, 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_read_drop", mem_read, 1'b0);
    chk("mid_owner", owner, 2'b00);
    chk("mid_err_clr", err_timeout, 1'b0);
    @(negedge clk);
    rst_n = 1;
    wait_grant(idle, ok);
    chk("mid_regrant_lat", idle, 0);
    chk("mid_regrant", owner, 2'b01);
    chk("mid_regrant_addr", mem_addr, 28'h0000333);
    pulse_ready(1'b0);
    @(negedge clk);
    mem_ready = 0; clear_req();
    @(negedge clk); #1;
    chk("final_idle", owner, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
